// File: rtl/id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register of the 5-stage RISC-V core. Captures the decoded
// control bits, operands and register addresses from ID on every rising edge,
// and acts on the hazard unit's requests:
//   - flush_IDEX  : squash (branch/jump taken in EX) -> load a bubble
//   - hold_IDEX   : downstream memory stall          -> freeze every field
//   - ctlRst_IDEX : load-use hazard                  -> insert a bubble
// Priority per edge: rst > flush_IDEX > hold_IDEX > ctlRst_IDEX > normal load.
//
// A bubble clears all 1-bit control bits and aluOp, drops valid and forces
// rd_IDEX to x0, so a bubble can never write a register or memory, and
// forwarding never matches on it. A flush additionally clears rs1/rs2_IDEX.
// Operand data (pc, rs1Data, rs2Data, imm, funct) always loads from ID unless
// the stage is held, which keeps the bubble contents deterministic.
//
// Optional feature (macro PERF_CNT_EN):
//   bubbleCnt counts ctlRst bubbles that actually got inserted, flushCnt
//   counts flush edges. Both saturate at all-ones and are cleared by rst.
//   Without the macro the counter ports and logic do not exist.
//
// Parameters:
//   XLEN   data / PC width
//   CNT_W  performance counter width (only meaningful with PERF_CNT_EN)
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ctlRst_IDEX, flush_IDEX,
//   hold_IDEX                        hazard unit requests
//   regWrite_ID .. branch_ID         decoded 1-bit controls
//   aluOp_ID [1:0], funct_ID [3:0]   ALU op class, {funct7[5], funct3}
//   pc_ID, rs1Data_ID, rs2Data_ID,
//   imm_ID [XLEN-1:0]                operands
//   rs1_ID, rs2_ID, rd_ID [4:0]      register addresses
//   *_IDEX                           registered copies of the above
//   valid_IDEX                       stage holds a real instruction
//   bubbleCnt, flushCnt [CNT_W-1:0]  performance counters (PERF_CNT_EN)
// ----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ctlRst_IDEX,
    input  logic            flush_IDEX,
    input  logic            hold_IDEX,

    input  logic            regWrite_ID,
    input  logic            memRead_ID,
    input  logic            memWrite_ID,
    input  logic            memToReg_ID,
    input  logic            aluSrc_ID,
    input  logic            branch_ID,
    input  logic [1:0]      aluOp_ID,
    input  logic [3:0]      funct_ID,

    input  logic [XLEN-1:0] pc_ID,
    input  logic [XLEN-1:0] rs1Data_ID,
    input  logic [XLEN-1:0] rs2Data_ID,
    input  logic [XLEN-1:0] imm_ID,

    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_ID,

    output logic            regWrite_IDEX,
    output logic            memRead_IDEX,
    output logic            memWrite_IDEX,
    output logic            memToReg_IDEX,
    output logic            aluSrc_IDEX,
    output logic            branch_IDEX,
    output logic [1:0]      aluOp_IDEX,
    output logic [3:0]      funct_IDEX,

    output logic [XLEN-1:0] pc_IDEX,
    output logic [XLEN-1:0] rs1Data_IDEX,
    output logic [XLEN-1:0] rs2Data_IDEX,
    output logic [XLEN-1:0] imm_IDEX,

    output logic [4:0]      rs1_IDEX,
    output logic [4:0]      rs2_IDEX,
    output logic [4:0]      rd_IDEX,

    output logic            valid_IDEX
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubbleCnt,
    output logic [CNT_W-1:0] flushCnt
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time sanity check on the counter width.
    // ------------------------------------------------------------------------
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("id_ex_stage_reg: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Stage payload, grouped by how a bubble treats each field.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic [1:0] aluOp;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1Data;
        logic [XLEN-1:0] rs2Data;
        logic [XLEN-1:0] imm;
        logic [3:0]      funct;
    } data_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } addr_t;

    ctrl_t ctrl_in, ctrl_d, ctrl_q;
    data_t data_in, data_d, data_q;
    addr_t addr_in, addr_d, addr_q;
    logic  valid_d, valid_q;
    logic  load_en;

    // Gather the ID-side inputs into the payload structs.
    assign ctrl_in = '{
        regWrite: regWrite_ID,
        memRead:  memRead_ID,
        memWrite: memWrite_ID,
        memToReg: memToReg_ID,
        aluSrc:   aluSrc_ID,
        branch:   branch_ID,
        aluOp:    aluOp_ID
    };

    assign data_in = '{
        pc:      pc_ID,
        rs1Data: rs1Data_ID,
        rs2Data: rs2Data_ID,
        imm:     imm_ID,
        funct:   funct_ID
    };

    assign addr_in = '{
        rs1: rs1_ID,
        rs2: rs2_ID,
        rd:  rd_ID
    };

    // ------------------------------------------------------------------------
    // Next-state selection. Hold is handled by the load enable below, so only
    // flush and ctlRst shape the value that gets loaded.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        ctrl_d  = ctrl_in;
        data_d  = data_in;
        addr_d  = addr_in;
        valid_d = 1'b1;

        if (flush_IDEX) begin
            // Squash: no side effects and no register dependencies survive.
            ctrl_d  = '0;
            addr_d  = '0;
            valid_d = 1'b0;
        end else if (ctlRst_IDEX) begin
            // Load-use bubble: rs1/rs2 still load because IF/ID is frozen and
            // the same instruction re-presents next cycle.
            ctrl_d    = '0;
            addr_d.rd = 5'd0;
            valid_d   = 1'b0;
        end
    end

    // A flush must win over hold so a squashed instruction never lingers.
    assign load_en = flush_IDEX | ~hold_IDEX;

    // ------------------------------------------------------------------------
    // Stage register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_en) begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Outputs come straight from the registers: no input-to-output path.
    assign regWrite_IDEX = ctrl_q.regWrite;
    assign memRead_IDEX  = ctrl_q.memRead;
    assign memWrite_IDEX = ctrl_q.memWrite;
    assign memToReg_IDEX = ctrl_q.memToReg;
    assign aluSrc_IDEX   = ctrl_q.aluSrc;
    assign branch_IDEX   = ctrl_q.branch;
    assign aluOp_IDEX    = ctrl_q.aluOp;
    assign funct_IDEX    = data_q.funct;

    assign pc_IDEX       = data_q.pc;
    assign rs1Data_IDEX  = data_q.rs1Data;
    assign rs2Data_IDEX  = data_q.rs2Data;
    assign imm_IDEX      = data_q.imm;

    assign rs1_IDEX      = addr_q.rs1;
    assign rs2_IDEX      = addr_q.rs2;
    assign rd_IDEX       = addr_q.rd;

    assign valid_IDEX    = valid_q;

`ifdef PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters. A bubble only counts when it is really
    // inserted, i.e. not masked by a flush or a hold on the same edge.
    // ------------------------------------------------------------------------
    logic bubble_evt;
    logic flush_evt;

    assign bubble_evt = ctlRst_IDEX & ~flush_IDEX & ~hold_IDEX;
    assign flush_evt  = flush_IDEX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubbleCnt <= '0;
            flushCnt  <= '0;
        end else begin
            if (bubble_evt && (bubbleCnt != '1)) begin
                bubbleCnt <= bubbleCnt + 1'b1;
            end
            if (flush_evt && (flushCnt != '1)) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed, self-checking bench for id_ex_stage_reg. Each scenario task drives
// the ID side and the hazard controls, waits for the edge, and compares the
// registered outputs 1 time unit later against hand-computed values. The
// counter checks are compiled in when PERF_CNT_EN is defined; the DUT is
// instantiated with CNT_W = 4 so saturation is reached quickly.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_id_ex_stage_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic            clk;
    logic            rst;
    logic            ctlRst_IDEX, flush_IDEX, hold_IDEX;
    logic            regWrite_ID, memRead_ID, memWrite_ID, memToReg_ID;
    logic            aluSrc_ID, branch_ID;
    logic [1:0]      aluOp_ID;
    logic [3:0]      funct_ID;
    logic [XLEN-1:0] pc_ID, rs1Data_ID, rs2Data_ID, imm_ID;
    logic [4:0]      rs1_ID, rs2_ID, rd_ID;

    logic            regWrite_IDEX, memRead_IDEX, memWrite_IDEX, memToReg_IDEX;
    logic            aluSrc_IDEX, branch_IDEX;
    logic [1:0]      aluOp_IDEX;
    logic [3:0]      funct_IDEX;
    logic [XLEN-1:0] pc_IDEX, rs1Data_IDEX, rs2Data_IDEX, imm_IDEX;
    logic [4:0]      rs1_IDEX, rs2_IDEX, rd_IDEX;
    logic            valid_IDEX;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] bubbleCnt, flushCnt;
`endif

    int n_cmp;
    int n_mis;
    int exp_bubble;
    int exp_flush;

    id_ex_stage_reg #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctlRst_IDEX   (ctlRst_IDEX),
        .flush_IDEX    (flush_IDEX),
        .hold_IDEX     (hold_IDEX),
        .regWrite_ID   (regWrite_ID),
        .memRead_ID    (memRead_ID),
        .memWrite_ID   (memWrite_ID),
        .memToReg_ID   (memToReg_ID),
        .aluSrc_ID     (aluSrc_ID),
        .branch_ID     (branch_ID),
        .aluOp_ID      (aluOp_ID),
        .funct_ID      (funct_ID),
        .pc_ID         (pc_ID),
        .rs1Data_ID    (rs1Data_ID),
        .rs2Data_ID    (rs2Data_ID),
        .imm_ID        (imm_ID),
        .rs1_ID        (rs1_ID),
        .rs2_ID        (rs2_ID),
        .rd_ID         (rd_ID),
        .regWrite_IDEX (regWrite_IDEX),
        .memRead_IDEX  (memRead_IDEX),
        .memWrite_IDEX (memWrite_IDEX),
        .memToReg_IDEX (memToReg_IDEX),
        .aluSrc_IDEX   (aluSrc_IDEX),
        .branch_IDEX   (branch_IDEX),
        .aluOp_IDEX    (aluOp_IDEX),
        .funct_IDEX    (funct_IDEX),
        .pc_IDEX       (pc_IDEX),
        .rs1Data_IDEX  (rs1Data_IDEX),
        .rs2Data_IDEX  (rs2Data_IDEX),
        .imm_IDEX      (imm_IDEX),
        .rs1_IDEX      (rs1_IDEX),
        .rs2_IDEX      (rs2_IDEX),
        .rd_IDEX       (rd_IDEX),
        .valid_IDEX    (valid_IDEX)
`ifdef PERF_CNT_EN
        ,
        .bubbleCnt     (bubbleCnt),
        .flushCnt      (flushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctlRst_IDEX = 1'b0; flush_IDEX = 1'b0; hold_IDEX = 1'b0;
        regWrite_ID = 1'b0; memRead_ID = 1'b0; memWrite_ID = 1'b0;
        memToReg_ID = 1'b0; aluSrc_ID = 1'b0; branch_ID = 1'b0;
        aluOp_ID = 2'd0; funct_ID = 4'd0;
        pc_ID = '0; rs1Data_ID = '0; rs2Data_ID = '0; imm_ID = '0;
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_ID = 5'd0;
    endtask

    // Bench-side counter model, advanced once per edge by the scenario.
    task automatic note_bubble();
        if (exp_bubble != 15) exp_bubble++;
    endtask

    task automatic note_flush();
        if (exp_flush != 15) exp_flush++;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Power-on reset.
        n_cmp++;
        if ({valid_IDEX, regWrite_IDEX, memRead_IDEX, memWrite_IDEX, rd_IDEX, pc_IDEX} !== '0) begin
            n_mis++;
            $display("FAIL reset_por: valid=%0b rw=%0b mr=%0b mw=%0b rd=%0d pc=%h required all 0",
                     valid_IDEX, regWrite_IDEX, memRead_IDEX, memWrite_IDEX, rd_IDEX, pc_IDEX);
        end
        rst = 1'b0;

        // Load a real instruction, then reset mid-cycle.
        regWrite_ID = 1'b1; memWrite_ID = 1'b1; rd_ID = 5'd9; rs1_ID = 5'd2;
        pc_ID = 32'h0000_0100; rs1Data_ID = 32'hDEAD_BEEF; aluOp_ID = 2'd2;
        step();
        n_cmp++;
        if (valid_IDEX !== 1'b1 || rd_IDEX !== 5'd9) begin
            n_mis++;
            $display("FAIL reset_preload: valid=%0b rd=%0d required 1 / 9", valid_IDEX, rd_IDEX);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({valid_IDEX, regWrite_IDEX, memWrite_IDEX, aluOp_IDEX, rd_IDEX, rs1_IDEX,
             pc_IDEX, rs1Data_IDEX} !== '0) begin
            n_mis++;
            $display("FAIL reset_async: valid=%0b rw=%0b mw=%0b aluop=%0d rd=%0d rs1=%0d pc=%h rs1d=%h required all 0",
                     valid_IDEX, regWrite_IDEX, memWrite_IDEX, aluOp_IDEX, rd_IDEX, rs1_IDEX,
                     pc_IDEX, rs1Data_IDEX);
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (bubbleCnt !== 4'd0 || flushCnt !== 4'd0) begin
            n_mis++;
            $display("FAIL reset_counters: bubble=%0d flush=%0d required 0 / 0", bubbleCnt, flushCnt);
        end
`endif
        // Release; the first edge afterwards is a normal load.
        #2 rst = 1'b0;
        idle_inputs();
        memToReg_ID = 1'b1; rd_ID = 5'd4; pc_ID = 32'h0000_0104;
        step();
        n_cmp++;
        if (valid_IDEX !== 1'b1 || memToReg_IDEX !== 1'b1 || rd_IDEX !== 5'd4 ||
            pc_IDEX !== 32'h0000_0104) begin
            n_mis++;
            $display("FAIL reset_release_load: valid=%0b m2r=%0b rd=%0d pc=%h required 1 / 1 / 4 / 00000104",
                     valid_IDEX, memToReg_IDEX, rd_IDEX, pc_IDEX);
        end
    endtask

    task automatic test_normal_load();
        idle_inputs();
        regWrite_ID = 1'b1; rd_ID = 5'd5; rs1Data_ID = 32'h0000_1234; pc_ID = 32'h0000_0040;
        step();
        n_cmp++;
        if (regWrite_IDEX !== 1'b1 || rd_IDEX !== 5'd5 || rs1Data_IDEX !== 32'h0000_1234 ||
            pc_IDEX !== 32'h0000_0040 || valid_IDEX !== 1'b1) begin
            n_mis++;
            $display("FAIL normal_load: rw=%0b rd=%0d rs1d=%h pc=%h valid=%0b required 1 / 5 / 00001234 / 00000040 / 1",
                     regWrite_IDEX, rd_IDEX, rs1Data_IDEX, pc_IDEX, valid_IDEX);
        end

        // Every field with a distinct, non-zero pattern.
        idle_inputs();
        memWrite_ID = 1'b1; aluSrc_ID = 1'b1; branch_ID = 1'b1; aluOp_ID = 2'd3;
        funct_ID = 4'hA; pc_ID = 32'h8000_0010; rs1Data_ID = 32'h0102_0304;
        rs2Data_ID = 32'hA5A5_5A5A; imm_ID = 32'hFFFF_FFF0;
        rs1_ID = 5'd17; rs2_ID = 5'd31; rd_ID = 5'd1;
        step();
        n_cmp++;
        if ({regWrite_IDEX, memRead_IDEX, memWrite_IDEX, memToReg_IDEX, aluSrc_IDEX, branch_IDEX}
                !== 6'b001011 || aluOp_IDEX !== 2'd3 || funct_IDEX !== 4'hA) begin
            n_mis++;
            $display("FAIL normal_ctrl: ctrl=%b aluop=%0d funct=%h required 001011 / 3 / a",
                     {regWrite_IDEX, memRead_IDEX, memWrite_IDEX, memToReg_IDEX, aluSrc_IDEX, branch_IDEX},
                     aluOp_IDEX, funct_IDEX);
        end
        n_cmp++;
        if (pc_IDEX !== 32'h8000_0010 || rs1Data_IDEX !== 32'h0102_0304 ||
            rs2Data_IDEX !== 32'hA5A5_5A5A || imm_IDEX !== 32'hFFFF_FFF0 ||
            rs1_IDEX !== 5'd17 || rs2_IDEX !== 5'd31 || rd_IDEX !== 5'd1) begin
            n_mis++;
            $display("FAIL normal_data: pc=%h rs1d=%h rs2d=%h imm=%h rs1=%0d rs2=%0d rd=%0d required 80000010 01020304 a5a55a5a fffffff0 17 31 1",
                     pc_IDEX, rs1Data_IDEX, rs2Data_IDEX, imm_IDEX, rs1_IDEX, rs2_IDEX, rd_IDEX);
        end
    endtask

    task automatic test_back_to_back();
        // A new instruction each cycle; each appears exactly one edge later.
        logic [XLEN-1:0] pcs [4];
        logic [4:0]      rds [4];
        pcs[0] = 32'h0000_0200; rds[0] = 5'd10;
        pcs[1] = 32'h0000_0204; rds[1] = 5'd11;
        pcs[2] = 32'h0000_0208; rds[2] = 5'd12;
        pcs[3] = 32'h0000_020C; rds[3] = 5'd13;
        idle_inputs();
        regWrite_ID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc_ID = pcs[i]; rd_ID = rds[i];
            step();
            n_cmp++;
            if (pc_IDEX !== pcs[i] || rd_IDEX !== rds[i] || valid_IDEX !== 1'b1) begin
                n_mis++;
                $display("FAIL b2b_%0d: pc=%h rd=%0d valid=%0b required %h / %0d / 1",
                         i, pc_IDEX, rd_IDEX, valid_IDEX, pcs[i], rds[i]);
            end
        end
        // Bubble, then the same instruction re-presented loads normally.
        ctlRst_IDEX = 1'b1; pc_ID = 32'h0000_0210; rd_ID = 5'd14;
        step();
        note_bubble();
        n_cmp++;
        if (valid_IDEX !== 1'b0 || rd_IDEX !== 5'd0 || regWrite_IDEX !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_bubble: valid=%0b rd=%0d rw=%0b required 0 / 0 / 0",
                     valid_IDEX, rd_IDEX, regWrite_IDEX);
        end
        ctlRst_IDEX = 1'b0;
        step();
        n_cmp++;
        if (valid_IDEX !== 1'b1 || rd_IDEX !== 5'd14 || pc_IDEX !== 32'h0000_0210) begin
            n_mis++;
            $display("FAIL b2b_represent: valid=%0b rd=%0d pc=%h required 1 / 14 / 00000210",
                     valid_IDEX, rd_IDEX, pc_IDEX);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        ctlRst_IDEX = 1'b1; memRead_ID = 1'b1; regWrite_ID = 1'b1; memWrite_ID = 1'b1;
        rd_ID = 5'd7; rs1_ID = 5'd3; rs2_ID = 5'd4; rs1Data_ID = 32'h0000_00AA;
        pc_ID = 32'h0000_0300;
        step();
        note_bubble();
        n_cmp++;
        if (memRead_IDEX !== 1'b0 || regWrite_IDEX !== 1'b0 || memWrite_IDEX !== 1'b0 ||
            rd_IDEX !== 5'd0 || valid_IDEX !== 1'b0) begin
            n_mis++;
            $display("FAIL loaduse_bubble: mr=%0b rw=%0b mw=%0b rd=%0d valid=%0b required 0 / 0 / 0 / 0 / 0",
                     memRead_IDEX, regWrite_IDEX, memWrite_IDEX, rd_IDEX, valid_IDEX);
        end
        n_cmp++;
        if (rs1_IDEX !== 5'd3 || rs2_IDEX !== 5'd4 || rs1Data_IDEX !== 32'h0000_00AA ||
            pc_IDEX !== 32'h0000_0300) begin
            n_mis++;
            $display("FAIL loaduse_passthru: rs1=%0d rs2=%0d rs1d=%h pc=%h required 3 / 4 / 000000aa / 00000300",
                     rs1_IDEX, rs2_IDEX, rs1Data_IDEX, pc_IDEX);
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (bubbleCnt !== exp_bubble[CNT_W-1:0]) begin
            n_mis++;
            $display("FAIL loaduse_bubblecnt: got %0d required %0d", bubbleCnt, exp_bubble);
        end
`endif
    endtask

    task automatic test_hold();
        idle_inputs();
        regWrite_ID = 1'b1; rd_ID = 5'd3; pc_ID = 32'h0000_0400; rs1Data_ID = 32'h1111_1111;
        step();
        // Hold together with ctlRst, with different ID values presented.
        hold_IDEX = 1'b1; ctlRst_IDEX = 1'b1;
        rd_ID = 5'd9; pc_ID = 32'h0000_0404; rs1Data_ID = 32'h2222_2222; memRead_ID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (rd_IDEX !== 5'd3 || valid_IDEX !== 1'b1 || regWrite_IDEX !== 1'b1 ||
                memRead_IDEX !== 1'b0 || pc_IDEX !== 32'h0000_0400 ||
                rs1Data_IDEX !== 32'h1111_1111) begin
                n_mis++;
                $display("FAIL hold_%0d: rd=%0d valid=%0b rw=%0b mr=%0b pc=%h rs1d=%h required 3 / 1 / 1 / 0 / 00000400 / 11111111",
                         i, rd_IDEX, valid_IDEX, regWrite_IDEX, memRead_IDEX, pc_IDEX, rs1Data_IDEX);
            end
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (bubbleCnt !== exp_bubble[CNT_W-1:0]) begin
            n_mis++;
            $display("FAIL hold_bubblecnt: got %0d required %0d", bubbleCnt, exp_bubble);
        end
`endif
    endtask

    task automatic test_flush_over_hold();
        // Stage still holds the rd=3 instruction from the hold scenario.
        idle_inputs();
        flush_IDEX = 1'b1; hold_IDEX = 1'b1; ctlRst_IDEX = 1'b1;
        regWrite_ID = 1'b1; memRead_ID = 1'b1; memWrite_ID = 1'b1; branch_ID = 1'b1;
        rd_ID = 5'd12; rs1_ID = 5'd1; rs2_ID = 5'd2; pc_ID = 32'h0000_0080;
        step();
        note_flush();
        n_cmp++;
        if (valid_IDEX !== 1'b0 ||
            {regWrite_IDEX, memRead_IDEX, memWrite_IDEX, memToReg_IDEX, aluSrc_IDEX, branch_IDEX} !== 6'b0 ||
            rd_IDEX !== 5'd0 || rs1_IDEX !== 5'd0 || rs2_IDEX !== 5'd0) begin
            n_mis++;
            $display("FAIL flush_bubble: valid=%0b ctrl=%b rd=%0d rs1=%0d rs2=%0d required 0 / 000000 / 0 / 0 / 0",
                     valid_IDEX,
                     {regWrite_IDEX, memRead_IDEX, memWrite_IDEX, memToReg_IDEX, aluSrc_IDEX, branch_IDEX},
                     rd_IDEX, rs1_IDEX, rs2_IDEX);
        end
        n_cmp++;
        if (pc_IDEX !== 32'h0000_0080) begin
            n_mis++;
            $display("FAIL flush_dataload: pc=%h required 00000080", pc_IDEX);
        end
`ifdef PERF_CNT_EN
        n_cmp++;
        if (flushCnt !== exp_flush[CNT_W-1:0] || bubbleCnt !== exp_bubble[CNT_W-1:0]) begin
            n_mis++;
            $display("FAIL flush_counters: flush=%0d bubble=%0d required %0d / %0d",
                     flushCnt, bubbleCnt, exp_flush, exp_bubble);
        end
`endif
    endtask

`ifdef PERF_CNT_EN
    task automatic test_saturation();
        idle_inputs();
        ctlRst_IDEX = 1'b1; rd_ID = 5'd6;
        for (int i = 0; i < 20; i++) begin
            step();
            note_bubble();
            if (i == 9) begin
                n_cmp++;
                if (bubbleCnt !== exp_bubble[CNT_W-1:0]) begin
                    n_mis++;
                    $display("FAIL sat_mid: got %0d required %0d", bubbleCnt, exp_bubble);
                end
            end
        end
        n_cmp++;
        if (bubbleCnt !== 4'd15) begin
            n_mis++;
            $display("FAIL sat_final: got %0d required 15", bubbleCnt);
        end
        // Reset clears the saturated counter.
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bubbleCnt !== 4'd0 || flushCnt !== 4'd0) begin
            n_mis++;
            $display("FAIL sat_reset: bubble=%0d flush=%0d required 0 / 0", bubbleCnt, flushCnt);
        end
        #2 rst = 1'b0;
        exp_bubble = 0;
        exp_flush  = 0;
    endtask
`endif

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_mis = 0;
        exp_bubble = 0;
        exp_flush  = 0;
        idle_inputs();
        rst = 1'b1;
        #22;

        test_reset();
        test_normal_load();
        test_back_to_back();
        test_load_use();
        test_hold();
        test_flush_over_hold();
`ifdef PERF_CNT_EN
        test_saturation();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
